// File: rtl/output_arbiter_21.sv
// Four-input output-port arbiter: round-robin grant with wormhole packet locking and downstream credit gating.
// Define PRESSURE_PRIO_EN to grant the fullest input FIFO first while idle.
module output_arbiter_21 #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
) (
  input  logic                fifo_clk,
  input  logic                rst,
  input  logic                N_valid_in,
  input  logic                E_valid_in,
  input  logic                W_valid_in,
  input  logic                L_valid_in,
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic [DATASIZE-1:0] E_data_in,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic [WIDTH:0]      N_pressure_in,
  input  logic [WIDTH:0]      E_pressure_in,
  input  logic [WIDTH:0]      W_pressure_in,
  input  logic [WIDTH:0]      L_pressure_in,
  output logic                fifo_ready_N,
  output logic                fifo_ready_E,
  output logic                fifo_ready_W,
  output logic                fifo_ready_L,
  input  logic [WIDTH:0]      out_pressure_in,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  output logic [1:0]          lock_owner,
  output logic                locked
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [WIDTH+1:0] DEPTH_W = (WIDTH+2)'(DEPTH);

  logic [0:0]          state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          owner_q, owner_d;
  logic [DATASIZE-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic [3:0]          valid_vec;
  logic [3:0]          elig;
  logic [DATASIZE-1:0] data_arr [4];
  logic [WIDTH+1:0]    fill_sum;
  logic                credit_ok;
  logic                grant_valid;
  logic [1:0]          grant_idx;
  logic [1:0]          scan_idx;
  logic                pop;
  logic [1:0]          flit_type;

  assign valid_vec   = {L_valid_in, W_valid_in, E_valid_in, N_valid_in};
  assign data_arr[0] = N_data_in;
  assign data_arr[1] = E_data_in;
  assign data_arr[2] = W_data_in;
  assign data_arr[3] = L_data_in;

  // Sum is one bit wider than the pressure bus so a full FIFO plus an in-flight write cannot wrap.
  assign fill_sum  = {1'b0, out_pressure_in} + {{(WIDTH+1){1'b0}}, out_valid_q};
  assign credit_ok = fill_sum < DEPTH_W;

  always_comb begin
    elig = '0;
    if (state_q == ST_IDLE) elig = valid_vec;
    else                    elig[owner_q] = valid_vec[owner_q];
  end

`ifdef PRESSURE_PRIO_EN
  logic [WIDTH:0] press_arr [4];
  logic [WIDTH:0] best_press;

  assign press_arr[0] = N_pressure_in;
  assign press_arr[1] = E_pressure_in;
  assign press_arr[2] = W_pressure_in;
  assign press_arr[3] = L_pressure_in;

  // Scan in round-robin order; strict '>' keeps the earliest requester on equal pressure.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    best_press  = '0;
    scan_idx    = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_ptr_q + 2'(i);
      if (elig[scan_idx] && (!grant_valid ||
          (state_q == ST_IDLE && press_arr[scan_idx] > best_press))) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
        best_press  = press_arr[scan_idx];
      end
    end
  end
`else
  logic unused_pressure;
  assign unused_pressure = ^{N_pressure_in, E_pressure_in, W_pressure_in, L_pressure_in};

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    scan_idx    = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_ptr_q + 2'(i);
      if (elig[scan_idx] && !grant_valid) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end
`endif

  assign pop       = grant_valid & credit_ok & ~rst;
  assign flit_type = data_arr[grant_idx][DATASIZE-1 -: 2];

  assign fifo_ready_N = pop & (grant_idx == 2'd0);
  assign fifo_ready_E = pop & (grant_idx == 2'd1);
  assign fifo_ready_W = pop & (grant_idx == 2'd2);
  assign fifo_ready_L = pop & (grant_idx == 2'd3);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    out_valid_d = pop;
    out_data_d  = pop ? data_arr[grant_idx] : out_data_q;
    if (pop) begin
      if (state_q == ST_IDLE) begin
        // Body/tail flits arriving while idle are treated like singles: no lock.
        if (flit_type == FT_HEAD) begin
          state_d = ST_LOCK;
          owner_d = grant_idx;
        end else begin
          rr_ptr_d = grant_idx + 2'd1;
        end
      end else if (flit_type == FT_TAIL || flit_type == FT_SINGLE) begin
        state_d  = ST_IDLE;
        rr_ptr_d = owner_q + 2'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is asynchronous, active-high.
  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 2'd0;
      owner_q     <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign lock_owner = owner_q;
  assign locked     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_output_arbiter_21.sv
// Directed self-checking bench for output_arbiter_21 (DEPTH=8, WIDTH=3, DATASIZE=40).
module tb_output_arbiter_21;

  localparam int DS = 40;

  logic          fifo_clk = 1'b0;
  logic          rst;
  logic          N_valid_in, E_valid_in, W_valid_in, L_valid_in;
  logic [DS-1:0] N_data_in, E_data_in, W_data_in, L_data_in;
  logic [3:0]    N_pressure_in, E_pressure_in, W_pressure_in, L_pressure_in;
  logic          fifo_ready_N, fifo_ready_E, fifo_ready_W, fifo_ready_L;
  logic [3:0]    out_pressure_in;
  logic [DS-1:0] out_data;
  logic          out_valid;
  logic [1:0]    lock_owner;
  logic          locked;
  logic [3:0]    rdy;

  int n_checks = 0;
  int n_pass   = 0;

  output_arbiter_21 #(.DEPTH(8), .WIDTH(3), .DATASIZE(DS)) dut (
    .fifo_clk(fifo_clk), .rst(rst),
    .N_valid_in(N_valid_in), .E_valid_in(E_valid_in),
    .W_valid_in(W_valid_in), .L_valid_in(L_valid_in),
    .N_data_in(N_data_in), .E_data_in(E_data_in),
    .W_data_in(W_data_in), .L_data_in(L_data_in),
    .N_pressure_in(N_pressure_in), .E_pressure_in(E_pressure_in),
    .W_pressure_in(W_pressure_in), .L_pressure_in(L_pressure_in),
    .fifo_ready_N(fifo_ready_N), .fifo_ready_E(fifo_ready_E),
    .fifo_ready_W(fifo_ready_W), .fifo_ready_L(fifo_ready_L),
    .out_pressure_in(out_pressure_in),
    .out_data(out_data), .out_valid(out_valid),
    .lock_owner(lock_owner), .locked(locked)
  );

  always #5 fifo_clk = ~fifo_clk;

  assign rdy = {fifo_ready_L, fifo_ready_W, fifo_ready_E, fifo_ready_N};

  function automatic logic [DS-1:0] flit(input logic [1:0] ft, input logic [7:0] tag);
    flit = {ft, 30'd0, tag};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge fifo_clk);
    #1;
  endtask

  task automatic clear_inputs();
    {N_valid_in, E_valid_in, W_valid_in, L_valid_in} = '0;
    N_data_in = '0; E_data_in = '0; W_data_in = '0; L_data_in = '0;
    {N_pressure_in, E_pressure_in, W_pressure_in, L_pressure_in} = '0;
    out_pressure_in = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    N_valid_in = 1'b1;
    N_data_in  = flit(2'b11, 8'h11);
    #3;
    check("rst_rdy",      64'(rdy), 64'h0);
    check("rst_valid",    64'(out_valid), 64'h0);
    check("rst_data",     64'(out_data), 64'h0);
    check("rst_locked",   64'(locked), 64'h0);
    check("rst_owner",    64'(lock_owner), 64'h0);
    tick(); tick();
    check("rst_hold_rdy", 64'(rdy), 64'h0);
    check("rst_hold_val", 64'(out_valid), 64'h0);

    // Two single flits from N and W
    rst = 1'b0;
    W_valid_in = 1'b1;
    W_data_in  = flit(2'b11, 8'h22);
    #1;
    check("rr_first_N",   64'(rdy), 64'b0001);
    tick();
    check("N_out_valid",  64'(out_valid), 64'h1);
    check("N_out_data",   64'(out_data), 64'(flit(2'b11, 8'h11)));
    N_valid_in = 1'b0;
    #1;
    check("rr_second_W",  64'(rdy), 64'b0100);
    tick();
    check("W_out_valid",  64'(out_valid), 64'h1);
    check("W_out_data",   64'(out_data), 64'(flit(2'b11, 8'h22)));
    W_valid_in = 1'b0;
    #1;
    check("none_rdy",     64'(rdy), 64'h0);
    tick();
    check("idle_valid",   64'(out_valid), 64'h0);
    check("idle_hold",    64'(out_data), 64'(flit(2'b11, 8'h22)));

    // E packet while L waits; rr restarted from N by reset
    pulse_reset();
    E_valid_in = 1'b1; E_data_in = flit(2'b10, 8'hE0);
    L_valid_in = 1'b1; L_data_in = flit(2'b11, 8'h44);
    #1;
    check("pkt_head_rdy", 64'(rdy), 64'b0010);
    check("pkt_pre_lock", 64'(locked), 64'h0);
    tick();
    check("pkt_locked",   64'(locked), 64'h1);
    check("pkt_owner",    64'(lock_owner), 64'h1);
    check("pkt_head_out", 64'(out_data), 64'(flit(2'b10, 8'hE0)));
    E_valid_in = 1'b0;
    #1;
    check("lock_stall",   64'(rdy), 64'h0);
    tick();
    check("stall_valid",  64'(out_valid), 64'h0);
    check("stall_locked", 64'(locked), 64'h1);
    E_valid_in = 1'b1; E_data_in = flit(2'b00, 8'hE1);
    #1;
    check("pkt_body_rdy", 64'(rdy), 64'b0010);
    tick();
    check("pkt_body_out", 64'(out_data), 64'(flit(2'b00, 8'hE1)));
    E_data_in = flit(2'b01, 8'hE2);
    #1;
    check("pkt_tail_rdy", 64'(rdy), 64'b0010);
    tick();
    check("pkt_tail_out", 64'(out_data), 64'(flit(2'b01, 8'hE2)));
    check("pkt_unlocked", 64'(locked), 64'h0);
    E_valid_in = 1'b0;
    #1;
    check("after_pkt_L",  64'(rdy), 64'b1000);
    tick();
    check("L_out_data",   64'(out_data), 64'(flit(2'b11, 8'h44)));
    L_valid_in = 1'b0;

    // Credit boundary: out_valid=1 here, rr back at N
    N_valid_in = 1'b1; N_data_in = flit(2'b11, 8'h55);
    out_pressure_in = 4'd7;
    #1;
    check("credit_7p1",   64'(rdy), 64'h0);
    tick();
    check("credit_noout", 64'(out_valid), 64'h0);
    out_pressure_in = 4'd6;
    #1;
    check("credit_6p0",   64'(rdy), 64'b0001);
    tick();
    check("credit_out",   64'(out_data), 64'(flit(2'b11, 8'h55)));
    out_pressure_in = 4'd15;
    N_data_in = flit(2'b11, 8'h66);
    #1;
    check("credit_nowrap", 64'(rdy), 64'h0);
    tick();
    out_pressure_in = 4'd7;
    #1;
    check("credit_7p0",   64'(rdy), 64'b0001);
    tick();
    check("credit_7_out", 64'(out_data), 64'(flit(2'b11, 8'h66)));
    clear_inputs();

    // Pressure priority (or its absence in the default build)
    pulse_reset();
    N_valid_in = 1'b1; N_data_in = flit(2'b11, 8'h70); N_pressure_in = 4'd2;
    L_valid_in = 1'b1; L_data_in = flit(2'b11, 8'h73); L_pressure_in = 4'd5;
    #1;
`ifdef PRESSURE_PRIO_EN
    check("prio_L",       64'(rdy), 64'b1000);
`else
    check("no_prio_N",    64'(rdy), 64'b0001);
`endif
    L_pressure_in = 4'd2;
    #1;
    check("prio_tie_N",   64'(rdy), 64'b0001);
    clear_inputs();

    // Reset while locked to W
    pulse_reset();
    W_valid_in = 1'b1; W_data_in = flit(2'b10, 8'h90);
    #1;
    check("w_head_rdy",   64'(rdy), 64'b0100);
    tick();
    check("w_locked",     64'(locked), 64'h1);
    check("w_owner",      64'(lock_owner), 64'h2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_lock", 64'(locked), 64'h0);
    check("mid_rst_val",  64'(out_valid), 64'h0);
    check("mid_rst_rdy",  64'(rdy), 64'h0);
    tick();
    rst = 1'b0;
    W_data_in  = flit(2'b00, 8'h91);
    E_valid_in = 1'b1; E_data_in = flit(2'b11, 8'h92);
    L_valid_in = 1'b1; L_data_in = flit(2'b11, 8'h93);
    #1;
    check("post_rst_E",   64'(rdy), 64'b0010);
    tick();
    check("post_rst_out", 64'(out_data), 64'(flit(2'b11, 8'h92)));
    check("post_rst_unl", 64'(locked), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
